tile_fwd_profiler: RTL and testbench
====================================

Name: tile_fwd_profiler

Overview:
- Windowed profiler that bind-attaches to a tile's forward network tx link.
- Classifies packets whose destination is a vcache row (north or south) and counts accepted packets and stall cycles per class over fixed-length sampling windows.
- Emits one timestamped record per window into a small FIFO drained by the trace consumer through a valid/yumi handshake.
- Replaces per-packet tracing with bounded-bandwidth summaries; adds backpressure accounting and drop tracking.

Parameters:
- addr_width_p, none (required), packet address width.
- data_width_p, none (required), packet data width.
- x_cord_width_p, none (required), x coordinate width.
- y_cord_width_p, none (required), y coordinate width.
- north_vc_y_p, 0, y coordinate of the north vcache row.
- south_vc_y_p, none (required), y coordinate of the south vcache row.
- window_p, 1024, cycles per sampling window; legal range 2..2^20.
- ctr_width_p, 16, width of each per-window counter.
- fifo_els_p, 4, record FIFO depth; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  profiling enable; level-sensitive.
- out_v_i  in  1  tx link valid.
- out_ready_i  in  1  tx link ready.
- out_packet_i  in  packet_width_lp  tx packet, cast to the manycore packet struct.
- global_ctr_i  in  32  global cycle counter.
- rec_v_o  out  1  a record is available.
- rec_o  out  rec_width_lp  head record, per the package struct.
- rec_yumi_i  in  1  consumer dequeues the head record.
- drop_cnt_o  out  16  records dropped because the FIFO was full; saturates.

Behaviour:
- Reset is asynchronous and active-low; flops clear the moment reset_n_i falls. Reset values: state IDLE, all counters 0, FIFO empty, rec_v_o=0, drop_cnt_o=0.
- Per-cycle event terms:
  - nv = dest y == north_vc_y_p
  - sv = dest y == south_vc_y_p
  - fire = out_v_i & out_ready_i
  - stall = out_v_i & ~out_ready_i
- Per-window counters, each ctr_width_p bits and saturating at all-ones: n_pkt, s_pkt, n_stall, s_stall. Any counter saturating sets the record's sat bit.
- Cycle counter cyc (clog2(window_p) bits) counts cycles spent in COUNT.
- FSM:
  - IDLE: when en_i=1, go to COUNT; counters and cyc are 0. Events are ignored in IDLE.
  - COUNT: accumulate events. If cyc==window_p-1, close the window: the record includes the current cycle's event, counters load 0, cyc=0, stay in COUNT. If en_i=0, go to FLUSH and do not count that cycle's event.
  - FLUSH: push the partial record (cycles = cyc value), clear counters, go to IDLE. The window-close push and the FLUSH push are the only push sources.
- Record fields:
  - stamp = global_ctr_i sampled on the push cycle
  - cycles: window_p for a full window, cyc for a partial one
  - n_pkt, s_pkt, n_stall, s_stall
  - sat
  - partial: 1 when the record comes from FLUSH
- Push handling: if the FIFO is full on a push cycle, the record is dropped and drop_cnt_o increments. A push and a yumi in the same cycle when full is not a drop; the dequeue frees a slot first.
- rec_yumi_i is legal only while rec_v_o=1. FIFO read latency is 0: rec_o is valid whenever rec_v_o=1.
- Record FIFO contents persist across the IDLE↔COUNT toggling of en_i; only reset clears them.
- Reset mid-window discards the partial window; nothing is emitted.

Optional Feature:
- Macro: TILE_FWD_PROFILER_DPI_EN.
- When defined: on each dequeue (rec_v_o & rec_yumi_i) the block calls the DPI function dpi_tile_fwd_profile(stamp, src_x, src_y, n_pkt, s_pkt, n_stall, s_stall, partial). src_x/src_y are latched from the first fired packet since reset; they are 0 if no packet has fired.
- When undefined: no DPI import, and the hardware outputs are unchanged.

Decomposition:
- Package bsg_manycore_profiler_pkg holds tile_fwd_profile_rec_s (the record struct), the rec_width_lp helper, and the FSM state enum {IDLE, COUNT, FLUSH}.
- The one natural sub-module is the record FIFO: reuse bsg_fifo_1r1w_small with els_p=fifo_els_p. The counters stay inline.

Test Plan:
- window_p=8, en_i=1, 3 fires to y=north_vc_y_p then idle; consumer yumis → one record with n_pkt=3, s_pkt=0, cycles=8, partial=0.
- A stall (v=1, ready=0) to south for 5 cycles, then a fire → s_stall=5, s_pkt=1.
- Fire on the window's final cycle → counted in the closing record; the next record's counts are 0.
- ctr_width_p=4, 20 north fires in one window → n_pkt=15, sat=1.
- fifo_els_p=2, no yumi for 4 windows → 2 records held, drop_cnt_o=2; yumi and push in the same cycle when full → no drop.
- en_i drops at cyc=5 → partial=1, cycles=5. Asserting reset_n_i=0 mid-window → rec_v_o=0 immediately, no record.

Source files
------------

// File: rtl/tile_fwd_profiler_pkg.sv
// -----------------------------------------------------------------------------
// bsg_manycore_profiler_pkg
//   Shared types for the tile forward-link profiler:
//   - tile_fwd_profile_rec_s : one per-window summary record. Counter fields
//     are 32 bits wide and zero-extended from the profiler's ctr_width_p
//     (ctr_width_p must be <= 32). The cycles field holds up to 2^20.
//   - rec_width_lp           : packed width of the record.
//   - prof_state_e           : profiler FSM states.
//   - packet_width()         : width of the manycore forward packet.
//     Packet layout, MSB to LSB:
//     {addr, op[1:0], reg_id[4:0], data, src_y, src_x, y, x}.
// -----------------------------------------------------------------------------
package bsg_manycore_profiler_pkg;

  localparam int rec_cycles_width_lp = 21;
  localparam int rec_ctr_width_lp    = 32;
  localparam int pkt_op_width_lp     = 2;
  localparam int pkt_reg_id_width_lp = 5;

  typedef struct packed {
    logic [31:0]                    stamp;
    logic [rec_cycles_width_lp-1:0] cycles;
    logic [rec_ctr_width_lp-1:0]    n_pkt;
    logic [rec_ctr_width_lp-1:0]    s_pkt;
    logic [rec_ctr_width_lp-1:0]    n_stall;
    logic [rec_ctr_width_lp-1:0]    s_stall;
    logic                           sat;
    logic                           partial;
  } tile_fwd_profile_rec_s;

  localparam int rec_width_lp = $bits(tile_fwd_profile_rec_s);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FLUSH = 2'd2
  } prof_state_e;

  function automatic int packet_width(input int addr_w, input int data_w,
                                      input int x_w, input int y_w);
    return addr_w + pkt_op_width_lp + pkt_reg_id_width_lp + data_w
           + 2 * (x_w + y_w);
  endfunction

endpackage

// File: rtl/tile_fwd_profiler_fifo.sv
// -----------------------------------------------------------------------------
// bsg_fifo_1r1w_small
//   Small register-based FIFO with zero read latency (data_o is the head entry
//   whenever v_o=1). ready_o also rises when the FIFO is full but the head is
//   being dequeued this cycle, so a write and a read may share a cycle at full.
//   Ports:
//     clk_i, reset_n_i     clock, asynchronous active-low reset
//     v_i, data_i, ready_o write side (v_i must only be set when ready_o=1)
//     v_o, data_o, yumi_i  read side (yumi_i only while v_o=1)
//   els_p must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = $clog2(els_p);

  logic [width_p-1:0]    mem_q [els_p];
  logic [ptr_width_lp:0] wptr_q, wptr_d;
  logic [ptr_width_lp:0] rptr_q, rptr_d;
  logic                  empty, full, enq, deq;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp])
              && (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);

  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];
  assign ready_o = ~full | yumi_i;

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  assign wptr_d = enq ? wptr_q + (ptr_width_lp+1)'(1) : wptr_q;
  assign rptr_d = deq ? rptr_q + (ptr_width_lp+1)'(1) : rptr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/tile_fwd_profiler.sv
// -----------------------------------------------------------------------------
// tile_fwd_profiler
//   Windowed profiler for a tile's forward-network tx link. Packets headed to
//   the north or south vcache row are counted (accepted packets and stall
//   cycles, per row) over fixed windows of window_p cycles; each window emits
//   one timestamped record into a small FIFO drained via valid/yumi.
//   Dropping en_i flushes the partial window as a record marked partial.
//   Ports:
//     clk_i, reset_n_i  clock, asynchronous active-low reset
//     en_i              profiling enable (level)
//     out_v_i, out_ready_i, out_packet_i   observed tx link
//     global_ctr_i      global cycle counter, sampled as the record stamp
//     rec_v_o, rec_o, rec_yumi_i           record FIFO head / dequeue
//     drop_cnt_o        saturating count of records lost to a full FIFO
// -----------------------------------------------------------------------------
module tile_fwd_profiler
  import bsg_manycore_profiler_pkg::*;
#(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 3,
  parameter int north_vc_y_p   = 0,
  parameter int south_vc_y_p   = 1,
  parameter int window_p       = 1024,
  parameter int ctr_width_p    = 16,
  parameter int fifo_els_p     = 4,
  localparam int packet_width_lp =
    packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic                       out_v_i,
  input  logic                       out_ready_i,
  input  logic [packet_width_lp-1:0] out_packet_i,
  input  logic [31:0]                global_ctr_i,
  output logic                       rec_v_o,
  output logic [rec_width_lp-1:0]    rec_o,
  input  logic                       rec_yumi_i,
  output logic [15:0]                drop_cnt_o
);

  localparam int cyc_width_lp = $clog2(window_p);
  localparam logic [cyc_width_lp-1:0] last_cyc_lp = cyc_width_lp'(window_p - 1);

  function automatic logic [ctr_width_p-1:0] sat_inc(
    input logic [ctr_width_p-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + ctr_width_p'(1);
    return v;
  endfunction

  // Destination row classification.
  logic [y_cord_width_p-1:0] dest_y;
  logic nv, sv, fire, stall;

  assign dest_y = out_packet_i[x_cord_width_p +: y_cord_width_p];
  assign nv     = (dest_y == y_cord_width_p'(north_vc_y_p));
  assign sv     = (dest_y == y_cord_width_p'(south_vc_y_p));
  assign fire   = out_v_i &  out_ready_i;
  assign stall  = out_v_i & ~out_ready_i;

  // Only the destination y is needed for classification.
  logic unused_pkt;
  assign unused_pkt = ^out_packet_i;

  prof_state_e             state_q, state_d;
  logic [cyc_width_lp-1:0] cyc_q, cyc_d;
  logic [ctr_width_p-1:0]  n_pkt_q, n_pkt_d, s_pkt_q, s_pkt_d;
  logic [ctr_width_p-1:0]  n_stall_q, n_stall_d, s_stall_q, s_stall_d;
  logic [15:0]             drop_q, drop_d;

  logic [ctr_width_p-1:0]  n_pkt_inc, s_pkt_inc, n_stall_inc, s_stall_inc;

  assign n_pkt_inc   = sat_inc(n_pkt_q,   fire  & nv);
  assign s_pkt_inc   = sat_inc(s_pkt_q,   fire  & sv);
  assign n_stall_inc = sat_inc(n_stall_q, stall & nv);
  assign s_stall_inc = sat_inc(s_stall_q, stall & sv);

  // Record being pushed this cycle (meaningful only when push=1).
  logic                           push;
  logic                           rec_partial;
  logic [rec_cycles_width_lp-1:0] rec_cycles;
  logic [ctr_width_p-1:0]         rec_n_pkt, rec_s_pkt, rec_n_stall, rec_s_stall;
  tile_fwd_profile_rec_s          rec_push;
  logic                           fifo_ready;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    n_pkt_d     = n_pkt_q;
    s_pkt_d     = s_pkt_q;
    n_stall_d   = n_stall_q;
    s_stall_d   = s_stall_q;
    push        = 1'b0;
    rec_partial = 1'b0;
    rec_cycles  = '0;
    rec_n_pkt   = n_pkt_q;
    rec_s_pkt   = s_pkt_q;
    rec_n_stall = n_stall_q;
    rec_s_stall = s_stall_q;

    unique case (state_q)
      IDLE: begin
        cyc_d     = '0;
        n_pkt_d   = '0;
        s_pkt_d   = '0;
        n_stall_d = '0;
        s_stall_d = '0;
        if (en_i) state_d = COUNT;
      end
      COUNT: begin
        if (!en_i) begin
          // The disabling cycle's event is not counted.
          state_d = FLUSH;
        end else if (cyc_q == last_cyc_lp) begin
          // Window close: the record includes this cycle's event.
          push        = 1'b1;
          rec_cycles  = rec_cycles_width_lp'(window_p);
          rec_n_pkt   = n_pkt_inc;
          rec_s_pkt   = s_pkt_inc;
          rec_n_stall = n_stall_inc;
          rec_s_stall = s_stall_inc;
          cyc_d       = '0;
          n_pkt_d     = '0;
          s_pkt_d     = '0;
          n_stall_d   = '0;
          s_stall_d   = '0;
        end else begin
          cyc_d     = cyc_q + cyc_width_lp'(1);
          n_pkt_d   = n_pkt_inc;
          s_pkt_d   = s_pkt_inc;
          n_stall_d = n_stall_inc;
          s_stall_d = s_stall_inc;
        end
      end
      FLUSH: begin
        push        = 1'b1;
        rec_partial = 1'b1;
        rec_cycles  = rec_cycles_width_lp'(cyc_q);
        cyc_d       = '0;
        n_pkt_d     = '0;
        s_pkt_d     = '0;
        n_stall_d   = '0;
        s_stall_d   = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rec_push         = '0;
    rec_push.stamp   = global_ctr_i;
    rec_push.cycles  = rec_cycles;
    rec_push.n_pkt   = rec_ctr_width_lp'(rec_n_pkt);
    rec_push.s_pkt   = rec_ctr_width_lp'(rec_s_pkt);
    rec_push.n_stall = rec_ctr_width_lp'(rec_n_stall);
    rec_push.s_stall = rec_ctr_width_lp'(rec_s_stall);
    rec_push.sat     = (rec_n_pkt == '1) | (rec_s_pkt == '1)
                     | (rec_n_stall == '1) | (rec_s_stall == '1);
    rec_push.partial = rec_partial;
  end

  // fifo_ready already accounts for a same-cycle dequeue at full.
  assign drop_d = (push && !fifo_ready && (drop_q != '1)) ? drop_q + 16'd1 : drop_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      n_pkt_q   <= '0;
      s_pkt_q   <= '0;
      n_stall_q <= '0;
      s_stall_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      n_pkt_q   <= n_pkt_d;
      s_pkt_q   <= s_pkt_d;
      n_stall_q <= n_stall_d;
      s_stall_q <= s_stall_d;
      drop_q    <= drop_d;
    end
  end

  assign drop_cnt_o = drop_q;

  bsg_fifo_1r1w_small #(
    .width_p (rec_width_lp),
    .els_p   (fifo_els_p)
  ) u_rec_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (push & fifo_ready),
    .ready_o   (fifo_ready),
    .data_i    (rec_push),
    .v_o       (rec_v_o),
    .data_o    (rec_o),
    .yumi_i    (rec_yumi_i)
  );

endmodule

// File: tb/tb_tile_fwd_profiler.sv
// -----------------------------------------------------------------------------
// tb_tile_fwd_profiler
//   Two profiler instances:
//     A: window 8,  16-bit counters, 2-entry FIFO
//     B: window 32, 4-bit counters,  4-entry FIFO (saturation)
//   Stimulus pushes the expected record into a per-instance queue; a monitor
//   running alongside pops and compares whenever a record is dequeued.
// -----------------------------------------------------------------------------
module tb_tile_fwd_profiler;
  import bsg_manycore_profiler_pkg::*;

  localparam int AW = 10, DW = 32, XW = 4, YW = 3;
  localparam int PW = packet_width(AW, DW, XW, YW);
  localparam int RW = rec_width_lp;
  localparam logic [YW-1:0] NY = 3'd0;
  localparam logic [YW-1:0] SY = 3'd5;
  localparam logic [YW-1:0] OY = 3'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   gctr = 32'd0;

  logic          en_a = 1'b0, v_a = 1'b0, rdy_a = 1'b0, drain_a = 1'b0;
  logic [PW-1:0] pkt_a = '0;
  logic          rec_v_a, yumi_a;
  logic [RW-1:0] rec_a;
  logic [15:0]   drop_a;

  logic          en_b = 1'b0, v_b = 1'b0, rdy_b = 1'b0, drain_b = 1'b0;
  logic [PW-1:0] pkt_b = '0;
  logic          rec_v_b, yumi_b;
  logic [RW-1:0] rec_b;
  logic [15:0]   drop_b;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  tile_fwd_profile_rec_s exp_a[$];
  tile_fwd_profile_rec_s exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) gctr <= gctr + 32'd1;

  assign yumi_a = drain_a & rec_v_a;
  assign yumi_b = drain_b & rec_v_b;

  tile_fwd_profiler #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .north_vc_y_p(0), .south_vc_y_p(5), .window_p(8), .ctr_width_p(16), .fifo_els_p(2)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_a), .out_v_i(v_a), .out_ready_i(rdy_a),
    .out_packet_i(pkt_a), .global_ctr_i(gctr), .rec_v_o(rec_v_a), .rec_o(rec_a),
    .rec_yumi_i(yumi_a), .drop_cnt_o(drop_a)
  );

  tile_fwd_profiler #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .north_vc_y_p(0), .south_vc_y_p(5), .window_p(32), .ctr_width_p(4), .fifo_els_p(4)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_b), .out_v_i(v_b), .out_ready_i(rdy_b),
    .out_packet_i(pkt_b), .global_ctr_i(gctr), .rec_v_o(rec_v_b), .rec_o(rec_b),
    .rec_yumi_i(yumi_b), .drop_cnt_o(drop_b)
  );

  function automatic logic [PW-1:0] mk_pkt(input logic [YW-1:0] y);
    logic [PW-1:0] p;
    p = '0;
    p[XW +: YW]        = y;
    p[XW+YW +: XW]     = 4'd2;
    p[2*XW+YW +: YW]   = 3'd1;
    return p;
  endfunction

  function automatic tile_fwd_profile_rec_s mk_rec(input logic [31:0] stamp, input int cycles,
      input int n, input int s, input int ns, input int ss, input logic sat, input logic partial);
    tile_fwd_profile_rec_s r;
    r.stamp   = stamp;
    r.cycles  = rec_cycles_width_lp'(cycles);
    r.n_pkt   = 32'(n);
    r.s_pkt   = 32'(s);
    r.n_stall = 32'(ns);
    r.s_stall = 32'(ss);
    r.sat     = sat;
    r.partial = partial;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic en, input logic v, input logic rdy, input logic [YW-1:0] y);
    en_a = en; v_a = v; rdy_a = rdy; pkt_a = mk_pkt(y);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_empty_a();
    for (int i = 0; i < 30; i++) begin
      if (!rec_v_a) break;
      step();
    end
    chk("drain_a_empty", 32'(rec_v_a), 32'd0);
  endtask

  task automatic wait_empty_b();
    for (int i = 0; i < 30; i++) begin
      if (!rec_v_b) break;
      step();
    end
    chk("drain_b_empty", 32'(rec_v_b), 32'd0);
  endtask

  task automatic do_reset();
    drv_a(1'b0, 1'b0, 1'b0, OY);
    en_b = 1'b0; v_b = 1'b0; rdy_b = 1'b0;
    drain_a = 1'b0; drain_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rec_v_a", 32'(rec_v_a), 32'd0);
    chk("reset_drop_a", 32'(drop_a), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic monitor();
    tile_fwd_profile_rec_s e;
    while (!done) begin
      @(negedge clk);
      if (rst_n && rec_v_a && yumi_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL rec_a unexpected actual=%h", rec_a);
        end else begin
          e = exp_a.pop_front();
          if (rec_a !== e) begin
            errors++;
            $display("FAIL rec_a actual=%h required=%h", rec_a, e);
          end
        end
      end
      if (rst_n && rec_v_b && yumi_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL rec_b unexpected actual=%h", rec_b);
        end else begin
          e = exp_b.pop_front();
          if (rec_b !== e) begin
            errors++;
            $display("FAIL rec_b actual=%h required=%h", rec_b, e);
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    // Power-on reset
    step();
    step();
    chk("por_rec_v_a", 32'(rec_v_a), 32'd0);
    chk("por_rec_v_b", 32'(rec_v_b), 32'd0);
    chk("por_drop_a", 32'(drop_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Three north fires in a full window
    drain_a = 1'b1;
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    drv_a(1'b1, 1'b1, 1'b1, NY); repeat (3) step();
    drv_a(1'b1, 1'b0, 1'b0, OY); repeat (4) step();
    exp_a.push_back(mk_rec(gctr, 8, 3, 0, 0, 0, 1'b0, 1'b0));
    step();
    wait_empty_a();
    do_reset();

    // Five south stall cycles then a south fire
    drain_a = 1'b1;
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    drv_a(1'b1, 1'b1, 1'b0, SY); repeat (5) step();
    drv_a(1'b1, 1'b1, 1'b1, SY); step();
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    exp_a.push_back(mk_rec(gctr, 8, 0, 1, 0, 5, 1'b0, 1'b0));
    step();
    wait_empty_a();
    do_reset();

    // Fire on the window's last cycle lands in that window only
    drain_a = 1'b1;
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    repeat (7) step();
    drv_a(1'b1, 1'b1, 1'b1, NY);
    exp_a.push_back(mk_rec(gctr, 8, 1, 0, 0, 0, 1'b0, 1'b0));
    step();
    drv_a(1'b1, 1'b0, 1'b0, OY); repeat (7) step();
    exp_a.push_back(mk_rec(gctr, 8, 0, 0, 0, 0, 1'b0, 1'b0));
    step();
    wait_empty_a();
    do_reset();

    // Full FIFO drops, then push+yumi at full is not a drop
    drain_a = 1'b0;
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    for (int w = 1; w <= 4; w++) begin
      repeat (7) step();
      if (w <= 2) exp_a.push_back(mk_rec(gctr, 8, 0, 0, 0, 0, 1'b0, 1'b0));
      step();
    end
    chk("full_drop_cnt", 32'(drop_a), 32'd2);
    chk("full_rec_v", 32'(rec_v_a), 32'd1);
    repeat (7) step();
    drain_a = 1'b1;
    exp_a.push_back(mk_rec(gctr, 8, 0, 0, 0, 0, 1'b0, 1'b0));
    step();
    drain_a = 1'b0;
    chk("yumi_push_no_drop", 32'(drop_a), 32'd2);
    drain_a = 1'b1;
    wait_empty_a();
    do_reset();

    // en_i falls with cyc=5: partial record
    drain_a = 1'b1;
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    drv_a(1'b1, 1'b1, 1'b1, NY); repeat (5) step();
    drv_a(1'b0, 1'b1, 1'b1, NY); step();
    drv_a(1'b0, 1'b0, 1'b0, OY);
    exp_a.push_back(mk_rec(gctr, 5, 5, 0, 0, 0, 1'b0, 1'b1));
    step();
    wait_empty_a();
    chk("partial_drop_cnt", 32'(drop_a), 32'd0);

    // Reset mid-window clears a held record immediately, nothing emitted after
    drain_a = 1'b0;
    drv_a(1'b1, 1'b0, 1'b0, OY); step();
    repeat (8) step();
    drv_a(1'b1, 1'b1, 1'b1, NY); repeat (3) step();
    chk("midwin_rec_v_held", 32'(rec_v_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwin_reset_rec_v", 32'(rec_v_a), 32'd0);
    drv_a(1'b0, 1'b0, 1'b0, OY);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("after_reset_rec_v", 32'(rec_v_a), 32'd0);

    // Counter saturation on instance B (4-bit counters)
    drain_b = 1'b1;
    en_b = 1'b1; step();
    v_b = 1'b1; rdy_b = 1'b1; pkt_b = mk_pkt(NY); repeat (20) step();
    v_b = 1'b0; rdy_b = 1'b0; pkt_b = mk_pkt(OY); repeat (11) step();
    exp_b.push_back(mk_rec(gctr, 32, 15, 0, 0, 0, 1'b1, 1'b0));
    step();
    wait_empty_b();
    chk("sat_drop_b", 32'(drop_b), 32'd0);
    do_reset();

    chk("exp_a_left", 32'(exp_a.size()), 32'd0);
    chk("exp_b_left", 32'(exp_b.size()), 32'd0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
